// File: rtl/traffic_pkg.sv
// traffic_pkg: shared parade FSM state type and light encodings for the intersection controller
package traffic_pkg;

    typedef enum logic {PARADE_OFF, PARADE_ON} parade_state_t;

    localparam logic [1:0] LIGHT_GREEN  = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_RED    = 2'd2;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer plus stable-count debounce for one loop detector
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw,
    output logic move
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // synchronize, then toggle move only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            move <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == move) begin
                cnt <= '0;
            end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
                move <= ~move;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: debounced move_a/move_b and parade-mode M for the light sequencer (optional auto-clear: PARADE_TIMEOUT_EN)
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PARADE_TIMEOUT  = 1024
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    input  logic P,
    input  logic R,
    output logic move_a,
    output logic move_b,
    output logic M,
    output logic parade_expired
);

    logic          p1, p2, p_prev;
    logic          r1, r2, r_prev;
    logic          p_rise;
    logic          r_rise;
    logic          timeout;
    parade_state_t state;
    parade_state_t state_n;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .CLK   (CLK),
        .reset (reset),
        .raw   (raw_a),
        .move  (move_a)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .CLK   (CLK),
        .reset (reset),
        .raw   (raw_b),
        .move  (move_b)
    );

    // synchronize buttons and keep one cycle of history for edge detection
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            p1     <= 1'b0;
            p2     <= 1'b0;
            p_prev <= 1'b0;
            r1     <= 1'b0;
            r2     <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            p1     <= P;
            p2     <= p1;
            p_prev <= p2;
            r1     <= R;
            r2     <= r1;
            r_prev <= r2;
        end
    end

    assign p_rise = p2 & ~p_prev;
    assign r_rise = r2 & ~r_prev;

`ifdef PARADE_TIMEOUT_EN
    localparam int TW = $clog2(PARADE_TIMEOUT);

    logic [TW-1:0] tcnt;

    assign timeout = (state == PARADE_ON) && (tcnt == TW'(PARADE_TIMEOUT - 1));

    // count cycles spent in PARADE_ON; a repeated P press does not restart it
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tcnt           <= '0;
            parade_expired <= 1'b0;
        end else begin
            tcnt           <= (state == PARADE_ON && state_n == PARADE_ON) ? tcnt + 1'b1 : '0;
            parade_expired <= timeout && !r_rise;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(PARADE_TIMEOUT);
    assign timeout        = 1'b0;
    assign parade_expired = 1'b0;
`endif

    // parade state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= PARADE_OFF;
        else       state <= state_n;
    end

    // next state: R beats a simultaneous P; timeout also ends the parade
    always_comb begin
        state_n = state;
        if (state == PARADE_OFF) state_n = (p_rise && !r_rise) ? PARADE_ON : PARADE_OFF;
        else                     state_n = (r_rise || timeout) ? PARADE_OFF : PARADE_ON;
    end

    assign M = (state == PARADE_ON);

endmodule
